// File: rtl/fetch_stage_unit.sv
// fetch_stage_unit
//   Instruction-fetch stage of the 5-stage ARM-subset pipeline. It holds the PC,
//   drives the instruction memory address, and latches the fetched word together
//   with its PC+4 into the IF/ID boundary. It obeys the hazard-unit load enable
//   (stall), redirects and flushes on a taken branch resolved in ID, and counts
//   stalled cycles in a saturating counter for bring-up.
//
// Ports
//   clk            in   system clock, all state updates on rising edge
//   reset          in   synchronous, active-high reset
//   hazard_ld      in   1 = PC and IF/ID load, 0 = stall (hold)
//   branch_taken   in   branch in ID taken this cycle
//   branch_target  in   byte address of branch destination
//   imem_en        out  instruction memory enable (combinational)
//   imem_addr      out  instruction memory byte address = PC (combinational)
//   imem_data      in   instruction word at imem_addr, valid same cycle
//   pc_out         out  current PC
//   if_id_instr    out  IF/ID instruction word
//   if_id_pc4      out  IF/ID PC+4 of the latched instruction
//   if_id_valid    out  if_id_instr is a real fetched instruction
//   fetch_misalign out  sticky: a redirect target had [1:0] != 0
//   stall_count    out  saturating count of stalled cycles
//   dbg_state      out  current FSM state (S_RESET=0, S_RUN=1, S_STALL=2)
//
// Handshake: there is no valid/ready pair here. hazard_ld acts as a load enable
// for the whole stage; when it is low every PC and IF/ID register holds, and the
// memory address stays stable. A taken branch overrides the stall.

module fetch_stage_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hazard_ld,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   output logic             imem_en,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      pc_out,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc4,
   output logic             if_id_valid,
   output logic             fetch_misalign,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        instr_q, instr_d;
   logic [31:0]        pc4_q, pc4_d;
   logic               valid_q, valid_d;
   logic               misalign_q, misalign_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic [31:0]        pc_plus4;

   // 32-bit modulo increment; wrapping past the top of memory is not flagged.
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      misalign_d  = misalign_q;
      stall_cnt_d = stall_cnt_q;
      imem_en     = 1'b0;

      if (state_q == S_RESET) begin
         // Idle cycle after reset: no fetch, bubble in IF/ID, PC holds.
         instr_d = NOP_INSTR;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
         state_d = S_RUN;
      end else begin
         imem_en = 1'b1;
         if (branch_taken) begin
            // Redirect wins over a stall: the word in IF/ID is on the wrong
            // path and is replaced by a bubble.
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            state_d = S_RUN;
            if (branch_target[1:0] != 2'b00) begin
               misalign_d = 1'b1;
            end
         end else if (!hazard_ld) begin
            state_d = S_STALL;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end else begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            state_d = S_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RESET;
         pc_q        <= RESET_PC;
         instr_q     <= NOP_INSTR;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
         misalign_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         misalign_q  <= misalign_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign imem_addr      = pc_q;
   assign pc_out         = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc4      = pc4_q;
   assign if_id_valid    = valid_q;
   assign fetch_misalign = misalign_q;
   assign stall_count    = stall_cnt_q;
   assign dbg_state      = state_q;

endmodule
